argmax_classifier: RTL and testbench

Final decision stage of the speech-recognition network. It sits directly downstream of `dense_layer_3` and consumes its ReLU-clamped `output_vector` of OUT_SIZE_3 signed 40-bit scores. On a start pulse it waits for the layer's serial accumulation to settle, then snapshots the vector and scans it one score per cycle. It reports the winning class index with a one-cycle valid pulse.

---
 rtl/nn_parameters_pkg.sv | 22 ++
 rtl/argmax_update.sv | 49 ++++
 rtl/argmax_classifier.sv | 190 +++++++++++++++++++
 tb/tb_argmax_classifier.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/nn_parameters_pkg.sv
// Network-wide sizes and shared types for the classifier back end.
// Used by argmax_classifier and argmax_update.
package nn_parameters;

    localparam int IN_SIZE_3     = 32;
    localparam int OUT_SIZE_3    = 12;
    localparam int ARGMAX_SETTLE = IN_SIZE_3 + 1;
    localparam int CLASS_ID_W    = $clog2(OUT_SIZE_3);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SCAN   = 2'd2,
        DONE   = 2'd3
    } argmax_state_e;

    // Index width that stays at least one bit for a single-class build.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/argmax_update.sv
// Combinational compare/update cell for one argmax scan step.
// Tracks the runner-up score when ARGMAX_MARGIN_EN is defined.
module argmax_update #(
    parameter int DATA_W = 40,
    parameter int ID_W   = 2
) (
    input  logic              first,
    input  logic [DATA_W-1:0] elem,
    input  logic [ID_W-1:0]   elem_idx,
    input  logic [DATA_W-1:0] best_val,
    input  logic [ID_W-1:0]   best_idx,
`ifdef ARGMAX_MARGIN_EN
    input  logic [DATA_W-1:0] second_val,
    output logic [DATA_W-1:0] second_val_nxt,
`endif
    output logic [DATA_W-1:0] best_val_nxt,
    output logic [ID_W-1:0]   best_idx_nxt
);

    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    always_comb begin
        best_val_nxt   = best_val;
        best_idx_nxt   = best_idx;
`ifdef ARGMAX_MARGIN_EN
        second_val_nxt = second_val;
`endif
        if (first) begin
            best_val_nxt   = elem;
            best_idx_nxt   = elem_idx;
`ifdef ARGMAX_MARGIN_EN
            second_val_nxt = MOST_NEG;
`endif
        end else if ($signed(elem) > $signed(best_val)) begin
            // Strict compare keeps the lowest index on ties.
            best_val_nxt   = elem;
            best_idx_nxt   = elem_idx;
`ifdef ARGMAX_MARGIN_EN
            second_val_nxt = best_val;
`endif
        end
`ifdef ARGMAX_MARGIN_EN
        else if ($signed(elem) > $signed(second_val)) begin
            second_val_nxt = elem;
        end
`endif
    end

endmodule

// File: rtl/argmax_classifier.sv
// Final argmax decision stage: settle, snapshot, serial scan, one-cycle result pulse.
// Optional winning margin output enabled by defining ARGMAX_MARGIN_EN.
//
// state  | meaning
// IDLE   | waiting for start
// SETTLE | upstream layer still accumulating; counting SETTLE_CYCLES
// SCAN   | one snapshot element compared per cycle
// DONE   | result registers valid, result_valid pulse
module argmax_classifier
    import nn_parameters::*;
#(
    parameter int N_CLASSES     = OUT_SIZE_3,
    parameter int DATA_W        = 40,
    parameter int SETTLE_CYCLES = ARGMAX_SETTLE,
    parameter int ID_W          = id_width(N_CLASSES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [DATA_W*N_CLASSES-1:0] score_vector,
    output logic                        busy,
    output logic                        result_valid,
    output logic [ID_W-1:0]             class_id,
    output logic                        no_detect
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic [DATA_W-1:0]           margin
`endif
);

    localparam int              CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ID_W-1:0]  IDX_LAST = ID_W'(N_CLASSES - 1);

    argmax_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0] snap_q [N_CLASSES];
    logic [DATA_W-1:0] snap_d [N_CLASSES];
    logic [DATA_W-1:0] best_val_q, best_val_d;
    logic [ID_W-1:0]   best_idx_q, best_idx_d;
    logic [ID_W-1:0]   class_id_q, class_id_d;
    logic              no_detect_q, no_detect_d;

    logic [DATA_W-1:0] elem;
    logic [DATA_W-1:0] upd_best_val;
    logic [ID_W-1:0]   upd_best_idx;

    always_comb begin
        elem = '0;
        for (int i = 0; i < N_CLASSES; i++) begin
            if (idx_q == ID_W'(i)) elem = snap_q[i];
        end
    end

`ifdef ARGMAX_MARGIN_EN
    localparam logic [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] second_val_q, second_val_d;
    logic [DATA_W-1:0] margin_q, margin_d;
    logic [DATA_W-1:0] upd_second_val;
    logic [DATA_W:0]   margin_diff;
    logic [DATA_W-1:0] margin_calc;

    always_comb begin
        margin_diff = {upd_best_val[DATA_W-1], upd_best_val}
                    - {upd_second_val[DATA_W-1], upd_second_val};
        if (N_CLASSES == 1) begin
            margin_calc = upd_best_val;
        end else if (margin_diff[DATA_W] != margin_diff[DATA_W-1]) begin
            margin_calc = margin_diff[DATA_W] ? NEG_MIN : POS_MAX;
        end else begin
            margin_calc = margin_diff[DATA_W-1:0];
        end
    end
`endif

    argmax_update #(
        .DATA_W (DATA_W),
        .ID_W   (ID_W)
    ) u_update (
        .first          (idx_q == '0),
        .elem           (elem),
        .elem_idx       (idx_q),
        .best_val       (best_val_q),
        .best_idx       (best_idx_q),
`ifdef ARGMAX_MARGIN_EN
        .second_val     (second_val_q),
        .second_val_nxt (upd_second_val),
`endif
        .best_val_nxt   (upd_best_val),
        .best_idx_nxt   (upd_best_idx)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        snap_d       = snap_q;
        best_val_d   = best_val_q;
        best_idx_d   = best_idx_q;
        class_id_d   = class_id_q;
        no_detect_d  = no_detect_q;
`ifdef ARGMAX_MARGIN_EN
        second_val_d = second_val_q;
        margin_d     = margin_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    for (int i = 0; i < N_CLASSES; i++) begin
                        snap_d[i] = score_vector[i*DATA_W +: DATA_W];
                    end
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                best_val_d   = upd_best_val;
                best_idx_d   = upd_best_idx;
`ifdef ARGMAX_MARGIN_EN
                second_val_d = upd_second_val;
`endif
                if (idx_q == IDX_LAST) begin
                    class_id_d  = upd_best_idx;
                    no_detect_d = (upd_best_val == '0);
`ifdef ARGMAX_MARGIN_EN
                    margin_d    = margin_calc;
`endif
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            for (int i = 0; i < N_CLASSES; i++) snap_q[i] <= '0;
            best_val_q   <= '0;
            best_idx_q   <= '0;
            class_id_q   <= '0;
            no_detect_q  <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
            second_val_q <= '0;
            margin_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            best_val_q   <= best_val_d;
            best_idx_q   <= best_idx_d;
            class_id_q   <= class_id_d;
            no_detect_q  <= no_detect_d;
`ifdef ARGMAX_MARGIN_EN
            second_val_q <= second_val_d;
            margin_q     <= margin_d;
`endif
        end
    end

    assign busy         = (state_q != IDLE);
    assign result_valid = (state_q == DONE);
    assign class_id     = class_id_q;
    assign no_detect    = no_detect_q;
`ifdef ARGMAX_MARGIN_EN
    assign margin       = margin_q;
`endif

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier (N_CLASSES=4, SETTLE_CYCLES=3).
// Margin checks are compiled in only when ARGMAX_MARGIN_EN is defined.
module tb_argmax_classifier;

    localparam int N  = 4;
    localparam int DW = 40;
    localparam int S  = 3;
    localparam int LAT = S + N + 1;

    logic            clk;
    logic            rst;
    logic            start;
    logic [DW*N-1:0] score_vector;
    logic            busy;
    logic            result_valid;
    logic [1:0]      class_id;
    logic            no_detect;
`ifdef ARGMAX_MARGIN_EN
    logic [DW-1:0]   margin;
`endif

    int n_pass  = 0;
    int n_total = 0;

    argmax_classifier #(
        .N_CLASSES     (N),
        .DATA_W        (DW),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .score_vector (score_vector),
        .busy         (busy),
        .result_valid (result_valid),
        .class_id     (class_id),
        .no_detect    (no_detect)
`ifdef ARGMAX_MARGIN_EN
        ,
        .margin       (margin)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_scores(input logic [DW-1:0] s0, input logic [DW-1:0] s1,
                              input logic [DW-1:0] s2, input logic [DW-1:0] s3);
        score_vector = {s3, s2, s1, s0};
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Edges counted from the edge that samples start (that edge is 1).
    task automatic wait_result(inout int edges);
        while (result_valid !== 1'b1 && edges < 60) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic run_case(input string tag, input int exp_id, input logic exp_nd,
                            input logic [DW-1:0] exp_margin);
        int edges;
        pulse_start();
        chk({tag, "_busy_rise"}, 64'(busy), 64'd1);
        edges = 1;
        wait_result(edges);
        chk({tag, "_latency"}, 64'(edges), 64'(LAT));
        chk({tag, "_class_id"}, 64'(class_id), 64'(exp_id));
        chk({tag, "_no_detect"}, 64'(no_detect), 64'(exp_nd));
`ifdef ARGMAX_MARGIN_EN
        chk({tag, "_margin"}, 64'(margin), 64'(exp_margin));
`else
        if (exp_margin != exp_margin) chk({tag, "_unused"}, 64'd0, 64'd1);
`endif
        @(negedge clk);
        chk({tag, "_pulse_one_cycle"}, 64'(result_valid), 64'd0);
        chk({tag, "_busy_fall"}, 64'(busy), 64'd0);
        chk({tag, "_id_held"}, 64'(class_id), 64'(exp_id));
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) pulses++;
        end
    endtask

    initial begin
        int edges;
        int pulses;
        rst = 1'b0;
        start = 1'b0;
        score_vector = '0;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(result_valid), 64'd0);
        chk("rst_class_id", 64'(class_id), 64'd0);
        chk("rst_no_detect", 64'(no_detect), 64'd0);
`ifdef ARGMAX_MARGIN_EN
        chk("rst_margin", 64'(margin), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b1;

        set_scores(40'd5, 40'd90, 40'd12, 40'd7);
        run_case("basic", 1, 1'b0, 40'd78);

        set_scores(40'd0, 40'd40, 40'd40, 40'd3);
        run_case("tie", 1, 1'b0, 40'd0);

        set_scores(40'd0, 40'd0, 40'd0, 40'd0);
        run_case("zeros", 0, 1'b1, 40'd0);

        set_scores(-40'sd5, -40'sd3, -40'sd9, -40'sd4);
        run_case("negative", 1, 1'b0, 40'd1);

        set_scores(40'h7F_FFFF_FFFF, 40'h80_0000_0000, 40'h80_0000_0000, 40'h80_0000_0000);
        run_case("saturate", 0, 1'b0, 40'h7F_FFFF_FFFF);

        // Snapshot stability plus an ignored start while busy.
        set_scores(40'd1, 40'd2, 40'd3, 40'd4);
        pulse_start();
        edges = 1;
        repeat (S) begin
            @(negedge clk);
            edges++;
        end
        set_scores(40'd99, 40'd0, 40'd0, 40'd0);
        @(negedge clk);
        edges++;
        start = 1'b1;
        @(negedge clk);
        edges++;
        start = 1'b0;
        wait_result(edges);
        chk("stable_latency", 64'(edges), 64'(LAT));
        chk("stable_class_id", 64'(class_id), 64'd3);
`ifdef ARGMAX_MARGIN_EN
        chk("stable_margin", 64'(margin), 64'd1);
`endif
        @(negedge clk);
        count_pulses(20, pulses);
        chk("busy_start_ignored", 64'(pulses), 64'd0);

        // Asynchronous reset in the middle of SCAN.
        set_scores(40'd20, 40'd30, 40'd40, 40'd50);
        pulse_start();
        repeat (S + 1) @(negedge clk);
        chk("pre_abort_busy", 64'(busy), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_valid", 64'(result_valid), 64'd0);
        chk("abort_class_id", 64'(class_id), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        count_pulses(20, pulses);
        chk("abort_no_pulse", 64'(pulses), 64'd0);
        chk("abort_idle", 64'(busy), 64'd0);

        set_scores(40'd9, 40'd1, 40'd1, 40'd1);
        run_case("after_reset", 0, 1'b0, 40'd8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
